// File: rtl/mul_mc_arbiter_pkg.sv
// rtl/mul_mc_arbiter_pkg.sv - shared types and helpers for the multiplier arbiter
package mul_mc_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    RESP,
    CLR_LOAD,
    CLR_RUN
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_multicycle.sv
// rtl/mul_multicycle.sv - shift-add multiplier, one partial product per unstopped cycle
module mul_multicycle #(
  parameter int NUM_BITS = 13
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                start,
  input  logic                stop,
  input  logic [NUM_BITS-1:0] op1,
  input  logic [NUM_BITS-1:0] op2,
  output logic [NUM_BITS-1:0] result,
  output logic                overflow,
  output logic                round_loss
);

  logic [2*NUM_BITS-1:0] prod;
  logic [NUM_BITS-1:0]   mcand;
  logic [NUM_BITS:0]     sum;

  assign sum = {1'b0, prod[2*NUM_BITS-1:NUM_BITS]} + (prod[0] ? {1'b0, mcand} : '0);

  // start only reloads the low half; whatever sits in the upper half is
  // accumulated into the next product, so callers must flush it first.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      prod  <= '0;
      mcand <= '0;
    end else if (start) begin
      prod  <= {prod[2*NUM_BITS-1:NUM_BITS], op2};
      mcand <= op1;
    end else if (!stop) begin
      prod  <= {sum, prod[NUM_BITS-1:1]};
    end
  end

  assign result     = prod[2*NUM_BITS-2:NUM_BITS-1];
  assign overflow   = prod[2*NUM_BITS-1];
  assign round_loss = |prod[NUM_BITS-2:0];

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  function automatic logic [ID_W-1:0] slot(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[slot(ptr, k)]) begin
        any               = 1'b1;
        idx               = slot(ptr, k);
        gnt[slot(ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_mc_arbiter.sv
// rtl/mul_mc_arbiter.sv - round-robin front end sharing one mul_multicycle
module mul_mc_arbiter
  import mul_mc_arbiter_pkg::*;
#(
  parameter int NUM_BITS = 13,
  parameter int NUM_REQ  = 2
) (
  input  logic                         clk,
  input  logic                         nRST,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_op1,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_op2,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [NUM_BITS-1:0]          resp_result,
  output logic                         resp_overflow,
  output logic                         resp_round_loss,
  output logic                         busy
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

  state_t              state, state_n;
  logic [ID_W-1:0]     rr_ptr, id_q, win_idx, ptr_next;
  logic [NUM_REQ-1:0]  win_gnt;
  logic                win_any;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_BITS-1:0] op1_q, op2_q, win_op1, win_op2, mul_op1, mul_op2;
  logic                mul_start, mul_stop;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(win_gnt),
    .idx(win_idx),
    .any(win_any)
  );

  assign win_op1  = req_op1[int'(win_idx)*NUM_BITS +: NUM_BITS];
  assign win_op2  = req_op2[int'(win_idx)*NUM_BITS +: NUM_BITS];
  assign ptr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + ID_W'(1);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    req_ready  = '0;
    resp_valid = 1'b0;
    mul_start  = 1'b0;
    mul_stop   = 1'b1;
    case (state)
      IDLE: begin
        if (win_any) begin
          req_ready = win_gnt;
          state_n   = LOAD;
        end
      end
      LOAD: begin
        mul_start = 1'b1;
        state_n   = RUN;
      end
      RUN: begin
        mul_stop = 1'b0;
        if (cnt == CNT_LAST) state_n = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = CLR_LOAD;
      end
      CLR_LOAD: begin
        mul_start = 1'b1;
        state_n   = CLR_RUN;
      end
      CLR_RUN: begin
        mul_stop = 1'b0;
        if (cnt == CNT_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= '0;
      cnt    <= '0;
      id_q   <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            id_q   <= win_idx;
            op1_q  <= win_op1;
            op2_q  <= win_op2;
            rr_ptr <= ptr_next;
          end
        end
        LOAD, CLR_LOAD: cnt <= '0;
        RUN, CLR_RUN:   cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Zero operands on the clear pass shift the stale upper half out.
  assign mul_op1 = (state == LOAD) ? op1_q : '0;
  assign mul_op2 = (state == LOAD) ? op2_q : '0;

  mul_multicycle #(
    .NUM_BITS(NUM_BITS)
  ) u_mul (
    .clk       (clk),
    .nRST      (nRST),
    .start     (mul_start),
    .stop      (mul_stop),
    .op1       (mul_op1),
    .op2       (mul_op2),
    .result    (resp_result),
    .overflow  (resp_overflow),
    .round_loss(resp_round_loss)
  );

  assign resp_id = id_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mul_mc_arbiter.sv
// tb/tb_mul_mc_arbiter.sv - scoreboard bench for mul_mc_arbiter
module tb_mul_mc_arbiter;

  localparam int NB = 13;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              nRST;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*NB-1:0]  req_op1, req_op2;
  logic              resp_valid, resp_ready;
  logic [0:0]        resp_id;
  logic [NB-1:0]     resp_result;
  logic              resp_overflow, resp_round_loss, busy;

  mul_mc_arbiter #(.NUM_BITS(NB), .NUM_REQ(NR)) dut (
    .clk(clk), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_round_loss(resp_round_loss),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            id;
    logic [NB-1:0] res;
    logic          ovf;
    logic          loss;
    int            gcyc;
  } exp_t;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 0;
  int   model_ptr = 0;
  int   grant_ids[$];
  int   grant_cycles[$];
  int   consumed = 0;
  int   mon_w;
  logic [NB-1:0] last_res;
  logic last_ovf, last_loss;
  int   last_id;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Reference: full-width integer product, then pick fields by weight.
  function automatic exp_t model(input int id, input logic [NB-1:0] a, input logic [NB-1:0] b, input int gc);
    longint unsigned p;
    exp_t e;
    p      = longint'(a) * longint'(b);
    e.id   = id;
    e.res  = NB'((p >> (NB - 1)) % (64'd1 << NB));
    e.ovf  = (p >= (64'd1 << (2*NB - 1)));
    e.loss = (p % (64'd1 << (NB - 1))) != 0;
    e.gcyc = gc;
    return e;
  endfunction

  // Monitor: predicts on grant, checks on every visible response cycle.
  initial forever begin
    @(negedge clk);
    if (!nRST) begin
      exp_q.delete();
      have_cur  = 0;
      model_ptr = 0;
    end else begin
      if (req_ready != '0) begin
        mon_w = -1;
        for (int k = 0; k < NR; k++)
          if (mon_w < 0 && req_valid[(model_ptr + k) % NR]) mon_w = (model_ptr + k) % NR;
        chk("grant_while_busy", 32'(exp_q.size()) + 32'(have_cur), 0);
        if (mon_w < 0) chk("grant_without_valid", 32'(req_ready), 0);
        else begin
          chk("grant_onehot", 32'(req_ready), 32'(1) << mon_w);
          exp_q.push_back(model(mon_w, req_op1[mon_w*NB +: NB], req_op2[mon_w*NB +: NB], cyc));
          grant_ids.push_back(mon_w);
          grant_cycles.push_back(cyc);
          model_ptr = (mon_w + 1) % NR;
        end
      end
      if (resp_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) chk("resp_without_request", 32'(exp_q.size()), 1);
          else begin
            cur      = exp_q.pop_front();
            have_cur = 1;
            chk("resp_latency", 32'(cyc - cur.gcyc), NB + 2);
          end
        end
        if (have_cur) begin
          chk("resp_id", 32'(resp_id), 32'(cur.id));
          chk("resp_result", 32'(resp_result), 32'(cur.res));
          chk("resp_overflow", 32'(resp_overflow), 32'(cur.ovf));
          chk("resp_round_loss", 32'(resp_round_loss), 32'(cur.loss));
        end
        last_res  = resp_result;
        last_ovf  = resp_overflow;
        last_loss = resp_round_loss;
        last_id   = int'(resp_id);
        if (resp_ready) begin
          have_cur = 0;
          consumed++;
        end
      end else if (have_cur) begin
        chk("resp_dropped", 32'(resp_valid), 1);
        have_cur = 0;
      end
    end
  end

  function automatic logic [NB-1:0] rand_op();
    case ($urandom_range(5, 0))
      0:       return '0;
      1:       return 13'h1FFF;
      2:       return 13'h0001;
      3:       return 13'h1000;
      default: return NB'($urandom);
    endcase
  endfunction

  task automatic hold_until_grant(input int i);
    bit got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
      @(posedge clk);
      #1;
    end
    req_valid[i] = 1'b0;
    if (!got) chk("grant_timeout", 32'(got), 1);
  endtask

  task automatic issue(input int i, input logic [NB-1:0] a, input logic [NB-1:0] b);
    req_op1[i*NB +: NB] = a;
    req_op2[i*NB +: NB] = b;
    req_valid[i] = 1'b1;
    hold_until_grant(i);
  endtask

  task automatic wait_consumed(input int target);
    for (int n = 0; n < 600 && consumed < target; n++) @(posedge clk);
    #1;
    if (consumed < target) chk("resp_timeout", 32'(consumed), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
    chk({tag, "_resp_id"}, 32'(resp_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [NR-1:0] acc;
  logic [NB-1:0] cap_res;
  logic cap_ovf, cap_loss;
  logic [0:0] cap_id;
  int g0, c0;

  initial begin
    nRST = 1'b0;
    req_valid = '0;
    req_op1 = '0;
    req_op2 = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 13'h1000, 13'h1000);
    wait_consumed(1);
    chk("t1_result", 32'(last_res), 32'h1000);
    chk("t1_flags", {30'd0, last_ovf, last_loss}, 0);
    chk("t1_id", 32'(last_id), 0);

    issue(1, 13'h1FFF, 13'h1FFF);
    wait_consumed(2);
    chk("t2_result", 32'(last_res), 32'h1FFC);
    chk("t2_flags", {30'd0, last_ovf, last_loss}, 3);
    chk("t2_id", 32'(last_id), 1);

    g0 = grant_cycles.size();
    issue(0, 13'h1FFF, 13'h1FFF);
    issue(0, 13'h0001, 13'h0001);
    wait_consumed(4);
    if (grant_cycles.size() >= g0 + 2)
      chk("b2b_spacing", 32'(grant_cycles[g0+1] - grant_cycles[g0]), 2*NB + 4);
    else chk("b2b_grants", 32'(grant_cycles.size() - g0), 2);
    chk("stale_result", 32'(last_res), 0);
    chk("stale_flags", {30'd0, last_ovf, last_loss}, 1);

    do_reset();
    g0 = grant_ids.size();
    c0 = consumed;
    for (int i = 0; i < NR; i++) begin
      req_op1[i*NB +: NB] = rand_op();
      req_op2[i*NB +: NB] = rand_op();
    end
    req_valid = '1;
    for (int n = 0; n < 400 && grant_ids.size() < g0 + 4; n++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (acc[i]) begin
          req_op1[i*NB +: NB] = rand_op();
          req_op2[i*NB +: NB] = rand_op();
        end
    end
    req_valid = '0;
    wait_consumed(c0 + 4);
    for (int k = 0; k < 4; k++)
      if (grant_ids.size() > g0 + k) chk("fair_order", 32'(grant_ids[g0+k]), 32'(k % 2));
      else chk("fair_missing", 32'(grant_ids.size()), 32'(g0 + 4));

    resp_ready = 1'b0;
    c0 = consumed;
    issue(0, rand_op(), rand_op());
    for (int n = 0; n < 100 && !resp_valid; n++) @(negedge clk);
    @(negedge clk);
    cap_res = resp_result;
    cap_ovf = resp_overflow;
    cap_loss = resp_round_loss;
    cap_id = resp_id;
    chk("bp_valid_start", 32'(resp_valid), 1);
    @(posedge clk);
    #1;
    req_op1[NB +: NB] = 13'h0123;
    req_op2[NB +: NB] = 13'h1ABC;
    req_valid[1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(resp_valid), 1);
      chk("bp_hold_fields", {12'd0, cap_res, cap_ovf, cap_loss, 5'd0, cap_id},
          {12'd0, resp_result, resp_overflow, resp_round_loss, 5'd0, resp_id});
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    chk("bp_none_consumed", 32'(consumed), 32'(c0));
    @(posedge clk);
    #1 resp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("bp_one_consumed", 32'(consumed), 32'(c0 + 1));
    hold_until_grant(1);
    wait_consumed(c0 + 2);

    issue(1, rand_op(), rand_op());
    repeat (5) @(posedge clk);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("midrun");
    repeat (3) @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    c0 = consumed;
    issue(0, 13'h0ABC, 13'h0123);
    wait_consumed(c0 + 1);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            req_op1[i*NB +: NB] = rand_op();
            req_op2[i*NB +: NB] = rand_op();
          end else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(4, 0) == 0) begin
          req_op1[i*NB +: NB] = rand_op();
          req_op2[i*NB +: NB] = rand_op();
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = ($urandom_range(3, 0) != 0);
    end
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int n = 0; n < 200 && (busy || exp_q.size() != 0 || have_cur); n++) @(posedge clk);
    #1 chk("drain", 32'(exp_q.size()) + 32'(have_cur), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
